// File: rtl/grey_pkg.sv
// Purpose: shared Johnson-code decade-digit constants and helper functions.
// Latency: n/a (package, combinational helpers only).
// Backpressure: n/a.
package grey_pkg;

    localparam int         DIGIT_W = 5;
    localparam logic [4:0] JC_ZERO = 5'b00000;
    localparam logic [4:0] JC_NINE = 5'b10000;

    // Count up one step: shift left, feed back the inverted MSB.
    function automatic logic [4:0] jc_inc(input logic [4:0] d);
        return {d[3:0], ~d[4]};
    endfunction

    // Count down one step: shift right, feed back the inverted LSB.
    function automatic logic [4:0] jc_dec(input logic [4:0] d);
        return {~d[0], d[4:1]};
    endfunction

    // Only the ten twisted-ring states are legal; the other 22 patterns are not.
    function automatic logic jc_valid(input logic [4:0] d);
        case (d)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Johnson code to binary 0..9; illegal codes decode to 4'hF.
    function automatic logic [3:0] jc_to_bcd(input logic [4:0] d);
        case (d)
            5'b00000: return 4'd0;
            5'b00001: return 4'd1;
            5'b00011: return 4'd2;
            5'b00111: return 4'd3;
            5'b01111: return 4'd4;
            5'b11111: return 4'd5;
            5'b11110: return 4'd6;
            5'b11100: return 4'd7;
            5'b11000: return 4'd8;
            5'b10000: return 4'd9;
            default:  return 4'hF;
        endcase
    endfunction

    // Prescaler width: $clog2(prescale), but never narrower than one bit.
    function automatic int pre_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/grey_digit.sv
// Purpose: one Johnson-coded decade digit with step/up/down, load and code check.
// Latency: q updates on the clock edge after step or load; nxt is the combinational next state.
// Backpressure: none; load wins over step, illegal init_d loads as zero.
import grey_pkg::*;

module grey_digit (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                up,
    input  logic                load,
    input  logic [DIGIT_W-1:0]  init_d,
    output logic [DIGIT_W-1:0]  q,
    output logic [DIGIT_W-1:0]  nxt,
    output logic                term,
    output logic                bad
);

    // Next-state selection, terminal detect and load-code check.
    always_comb begin
        bad  = !jc_valid(init_d);
        term = up ? (q == JC_NINE) : (q == JC_ZERO);
        nxt  = q;
        if (load) begin
            nxt = bad ? JC_ZERO : init_d;
        end else if (step) begin
            nxt = up ? jc_inc(q) : jc_dec(q);
        end
    end

    // Digit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= JC_ZERO;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/grey_counter_n.sv
// Purpose: N-digit Johnson-coded decade counter with prescale, up/down, load, wrap pulse and digit readout.
// Latency: Q, CARRY and DIGIT/BCD register one cycle after tick/load/SEL change.
// Backpressure: none; LOAD overrides tick, EN=0 freezes the prescaler.
import grey_pkg::*;

module grey_counter_n #(
    parameter int N_DIGITS = 12,
    parameter int PRESCALE = 1,
    parameter int SEL_W    = 6
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic                          UP,
    input  logic                          LOAD,
    input  logic [DIGIT_W*N_DIGITS-1:0]   INIT,
    input  logic [SEL_W-1:0]              SEL,
    output logic [DIGIT_W*N_DIGITS-1:0]   Q,
    output logic [DIGIT_W-1:0]            DIGIT,
    output logic [3:0]                    BCD,
    output logic                          CARRY,
    output logic                          ERR
);

    localparam int               PRE_W   = pre_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre;
    logic                tick;
    logic [N_DIGITS-1:0] term;
    logic [N_DIGITS-1:0] bad;
    logic [N_DIGITS-1:0] step;
    // run[i] is high when every digit below i is at its terminal value.
    logic [N_DIGITS:0]   run;
    logic [DIGIT_W-1:0]  q_d   [N_DIGITS];
    logic [DIGIT_W-1:0]  nxt_d [N_DIGITS];
    logic [DIGIT_W-1:0]  rd_dig;
    logic [3:0]          rd_bcd;

    assign tick   = EN && (pre == PRE_MAX);
    assign run[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign run[gi+1] = run[gi] & term[gi];
            assign step[gi]  = tick & run[gi];
            assign Q[DIGIT_W*gi +: DIGIT_W] = q_d[gi];

            grey_digit u_digit (
                .clk    (CLK),
                .rst    (RST),
                .step   (step[gi]),
                .up     (UP),
                .load   (LOAD),
                .init_d (INIT[DIGIT_W*gi +: DIGIT_W]),
                .q      (q_d[gi]),
                .nxt    (nxt_d[gi]),
                .term   (term[gi]),
                .bad    (bad[gi])
            );
        end
    endgenerate

    // Prescaler: counts enabled cycles, wraps on tick, cleared by load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre <= '0;
        end else if (LOAD || tick) begin
            pre <= '0;
        end else if (EN) begin
            pre <= pre + 1'b1;
        end
    end

    // Wrap pulse when every digit was terminal on a tick; sticky load-code error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CARRY <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            CARRY <= !LOAD && tick && run[N_DIGITS];
            ERR   <= ERR | (LOAD && (|bad));
        end
    end

    // Select the next-state digit so the readout lines up with Q.
    always_comb begin
        rd_dig = JC_ZERO;
        rd_bcd = 4'hF;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (SEL == SEL_W'(i)) begin
                rd_dig = nxt_d[i];
                rd_bcd = jc_to_bcd(nxt_d[i]);
            end
        end
    end

    // Registered digit readout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DIGIT <= JC_ZERO;
            BCD   <= 4'd0;
        end else begin
            DIGIT <= rd_dig;
            BCD   <= rd_bcd;
        end
    end

endmodule

// File: tb/tb_grey_counter_n.sv
// Purpose: scoreboard bench for grey_counter_n (3 digits, prescale 1 and prescale 4 instances).
// Latency: expectations are compared 1 ns after the clock edge that should produce them.
// Backpressure: n/a.
module tb_grey_counter_n;

    localparam logic [4:0] CODE_TAB [10] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
        5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [14:0] init;
    logic [1:0]  sel;

    logic [14:0] q,     q4;
    logic [4:0]  digit, digit4;
    logic [3:0]  bcd,   bcd4;
    logic        carry, carry4;
    logic        err,   err4;

    grey_counter_n #(.N_DIGITS(3), .PRESCALE(1), .SEL_W(2)) dut (
        .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .INIT(init), .SEL(sel),
        .Q(q), .DIGIT(digit), .BCD(bcd), .CARRY(carry), .ERR(err)
    );

    grey_counter_n #(.N_DIGITS(3), .PRESCALE(4), .SEL_W(2)) dut4 (
        .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .INIT(init), .SEL(sel),
        .Q(q4), .DIGIT(digit4), .BCD(bcd4), .CARRY(carry4), .ERR(err4)
    );

    always #5 clk = ~clk;

    typedef enum int {K_Q, K_CARRY, K_ERR, K_DIGIT, K_BCD, K_Q4} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [14:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [14:0] enc(input int n);
        return {CODE_TAB[(n / 100) % 10], CODE_TAB[(n / 10) % 10], CODE_TAB[n % 10]};
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input kind_t k, input logic [14:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    function automatic logic [14:0] observe(input kind_t k);
        case (k)
            K_Q:     return q;
            K_CARRY: return {14'd0, carry};
            K_ERR:   return {14'd0, err};
            K_DIGIT: return {10'd0, digit};
            K_BCD:   return {11'd0, bcd};
            K_Q4:    return q4;
            default: return 15'd0;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        init = '0;
        sel  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("rst_q",     K_Q,     15'd0);
        expect_out("rst_carry", K_CARRY, 15'd0);
        expect_out("rst_err",   K_ERR,   15'd0);
        expect_out("rst_digit", K_DIGIT, 15'd0);
        expect_out("rst_bcd",   K_BCD,   15'd0);
        expect_out("rst_q4",    K_Q4,    15'd0);
        drain();
        rst = 1'b0;

        // Test 1: async reset mid-cycle, then count up to 029.
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            expect_out("t1_pre_q", K_Q, enc(k));
            step();
        end
        #3 rst = 1'b1;
        #1;
        expect_out("t1_async_rst_q", K_Q, 15'd0);
        drain();
        #1 rst = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            expect_out("t1_count_q",     K_Q,     enc(k));
            expect_out("t1_count_carry", K_CARRY, 15'd0);
            if (k == 29) expect_out("t1_final_029", K_Q, 15'b00000_00011_10000);
            step();
        end

        // Test 2: wrap up from 999 and wrap down from 000, one-cycle CARRY.
        en   = 1'b0;
        load = 1'b1;
        init = {CODE_TAB[9], CODE_TAB[9], CODE_TAB[9]};
        expect_out("t2_load_q",     K_Q,     enc(999));
        expect_out("t2_load_carry", K_CARRY, 15'd0);
        expect_out("t2_load_err",   K_ERR,   15'd0);
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        expect_out("t2_wrap_up_q",     K_Q,     enc(0));
        expect_out("t2_wrap_up_carry", K_CARRY, 15'd1);
        step();
        en = 1'b0;
        expect_out("t2_hold_q",     K_Q,     enc(0));
        expect_out("t2_carry_drop", K_CARRY, 15'd0);
        step();
        up = 1'b0;
        en = 1'b1;
        expect_out("t2_wrap_dn_q",     K_Q,     enc(999));
        expect_out("t2_wrap_dn_carry", K_CARRY, 15'd1);
        step();
        en = 1'b0;
        expect_out("t2_carry_drop2", K_CARRY, 15'd0);
        step();

        // Test 3: illegal middle digit loads as zero and sets sticky ERR.
        load = 1'b1;
        init = {CODE_TAB[3], 5'b10101, CODE_TAB[3]};
        expect_out("t3_load_q",   K_Q,   enc(303));
        expect_out("t3_load_err", K_ERR, 15'd1);
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            if (k % 10 == 0) expect_out("t3_err_sticky", K_ERR, 15'd1);
            if (k == 50)     expect_out("t3_count_q",    K_Q,   enc(353));
            step();
        end
        en  = 1'b0;
        rst = 1'b1;
        #1;
        expect_out("t3_err_clear", K_ERR, 15'd0);
        expect_out("t3_rst_q4",    K_Q4,  15'd0);
        drain();
        rst = 1'b0;

        // Test 4: prescale 4 instance, EN pause holds the prescaler.
        en = 1'b1;
        up = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            expect_out("t4_pre_q4", K_Q4, enc(c / 4));
            step();
        end
        for (int c = 1; c <= 3; c++) begin
            expect_out("t4_pre_tail_q4", K_Q4, enc(4));
            step();
        end
        en = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            expect_out("t4_paused_q4", K_Q4, enc(4));
            step();
        end
        en = 1'b1;
        expect_out("t4_resume_q4", K_Q4, enc(5));
        step();

        // Test 5: LOAD beats tick and clears the prescaler.
        en   = 1'b1;
        load = 1'b1;
        init = enc(123);
        expect_out("t5_load_q",     K_Q,     enc(123));
        expect_out("t5_load_q4",    K_Q4,    enc(123));
        expect_out("t5_load_carry", K_CARRY, 15'd0);
        step();
        load = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            expect_out("t5_q",  K_Q,  enc(123 + c));
            expect_out("t5_q4", K_Q4, enc(c == 4 ? 124 : 123));
            step();
        end

        // Test 6: selected-digit readout.
        en   = 1'b0;
        load = 1'b1;
        init = enc(507);
        sel  = 2'd0;
        expect_out("t6_q",       K_Q,     enc(507));
        expect_out("t6_sel0_bcd", K_BCD,  15'd7);
        expect_out("t6_sel0_dig", K_DIGIT, {10'd0, CODE_TAB[7]});
        step();
        load = 1'b0;
        sel  = 2'd2;
        expect_out("t6_sel2_bcd", K_BCD,   15'd5);
        expect_out("t6_sel2_dig", K_DIGIT, 15'b11111);
        step();
        sel = 2'd1;
        expect_out("t6_sel1_bcd", K_BCD,   15'd0);
        expect_out("t6_sel1_dig", K_DIGIT, 15'd0);
        step();
        sel = 2'd3;
        expect_out("t6_sel3_bcd", K_BCD,   15'hF);
        expect_out("t6_sel3_dig", K_DIGIT, 15'd0);
        step();
        sel = 2'd0;
        en  = 1'b1;
        expect_out("t6_track_q",   K_Q,   enc(508));
        expect_out("t6_track_bcd", K_BCD, 15'd8);
        step();
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
